// File: rtl/pattern_scan_arbiter_if.sv
// Request/grant and result handshake bundle for pattern_scan_arbiter.
// The master side issues requests and consumes results; the slave side is the arbiter.
interface pattern_scan_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*WORD_W-1:0] data;
    logic [N_REQ-1:0]        gnt;
    logic                    busy;
    logic                    res_valid;
    logic [ID_W-1:0]         res_id;
    logic [2:0]              res_count;
    logic                    res_ready;

    modport master (
        output req, data, res_ready,
        input  gnt, busy, res_valid, res_id, res_count
    );

    modport slave (
        input  req, data, res_ready,
        output gnt, busy, res_valid, res_id, res_count
    );
endinterface

// File: rtl/pattern_scan_arbiter.sv
// Round-robin arbiter that grants one requester, scans its word MSB first for
// "1011" with a Moore detector, and returns the saturating match count.
module pattern_scan_arbiter #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8
) (
    input logic                 clk,
    input logic                 clear_n,
    pattern_scan_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int BIT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {D0, D1, D2, D3, D4} det_t;

    state_t            state;
    det_t              det_q;
    det_t              det_nx;
    logic [BIT_W-1:0]  bit_q;
    logic [2:0]        cnt_q;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id_q;
    logic [WORD_W-1:0] word_q;
    logic              busy_q;
    logic              vld_q;

    logic              pick_vld;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   cand;
    logic              grant;
    logic [N_REQ-1:0]  gnt_onehot;

    function automatic det_t det_next(input det_t s, input logic b);
        case (s)
            D0:      return b ? D1 : D0;
            D1:      return b ? D1 : D2;
            D2:      return b ? D3 : D0;
            D3:      return b ? D4 : D0;
            D4:      return b ? D1 : D0;
            default: return D0;
        endcase
    endfunction

    function automatic logic [2:0] sat_inc(input logic [2:0] c);
        return (c == 3'd7) ? c : c + 3'd1;
    endfunction

    // Walk downward from the farthest candidate so the one nearest ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + ID_W'(k);
            if (bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    // Gated by clear_n so no grant can escape while reset is held.
    assign grant = (state == IDLE) && pick_vld && clear_n;

    always_comb begin
        gnt_onehot = '0;
        if (grant) gnt_onehot[pick_id] = 1'b1;
    end

    assign det_nx = det_next(det_q, word_q[WORD_W-1]);

    // Controller and detector state
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state  <= IDLE;
            det_q  <= D0;
            bit_q  <= '0;
            cnt_q  <= '0;
            ptr    <= '0;
            busy_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state  <= SHIFT;
                        det_q  <= D0;
                        bit_q  <= '0;
                        cnt_q  <= '0;
                        ptr    <= pick_id + ID_W'(1);
                        busy_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    det_q <= det_nx;
                    if (det_nx == D4) cnt_q <= sat_inc(cnt_q);
                    bit_q <= bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(WORD_W - 1)) begin
                        state <= DONE;
                        vld_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state  <= IDLE;
                        vld_q  <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Captured word and owner; qualified by the controller, so no reset needed
    always_ff @(posedge clk) begin
        if (grant) begin
            word_q <= bus.data[pick_id*WORD_W +: WORD_W];
            id_q   <= pick_id;
        end else if (state == SHIFT) begin
            word_q <= {word_q[WORD_W-2:0], 1'b0};
        end
    end

    assign bus.gnt       = gnt_onehot;
    assign bus.busy      = busy_q;
    assign bus.res_valid = vld_q;
    assign bus.res_id    = vld_q ? id_q : '0;
    assign bus.res_count = vld_q ? cnt_q : '0;
endmodule

// File: doc/pattern_scan_arbiter.md
PATTERN_SCAN_ARBITER -- requirements
Module: pattern_scan_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (fixed at 4 for this release).
REQ-002 SHALL have parameter WORD_W, default 8, bits per request word.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port clear_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req  input  4  per-requester request level; bit i is requester i.
REQ-006 SHALL have port data  input  32  request words; requester i in data[8i+7:8i].
REQ-007 SHALL have port gnt  output  4  one-hot, one-cycle pulse; the word of the granted requester is captured in that cycle.
REQ-008 SHALL have port busy  output  1  high while in SHIFT or DONE.
REQ-009 SHALL have port res_valid  output  1  result available.
REQ-010 SHALL have port res_id  output  2  index of the requester that owns the result.
REQ-011 SHALL have port res_count  output  3  count of "1011" matches in the word.
REQ-012 SHALL have port res_ready  input  1  consumer accepts the result.

Function
REQ-013 SHALL implement a controller FSM with states IDLE, SHIFT and DONE.
REQ-014 In IDLE with req!=0, the block SHALL issue a gnt pulse for one requester, capture its word and index, clear the bit counter and match count, and move to SHIFT on the next edge.
REQ-015 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod 4; after reset it starts at index 0.
REQ-016 In IDLE with req==0, gnt SHALL stay 0 and the FSM SHALL remain in IDLE.
REQ-017 SHIFT SHALL last exactly 8 cycles and feed one captured bit per cycle, MSB first, into an internal Moore detector.
REQ-018 The detector SHALL use states D0..D4, reset to D0 at each grant. Transitions (in=1 / in=0):
- D0 -> D1 / D0
- D1 -> D1 / D2
- D2 -> D3 / D0
- D3 -> D4 / D0
- D4 -> D1 / D0
REQ-019 The match count SHALL increment, saturating at 7, on every SHIFT cycle whose detector next state is D4, including the 8th bit.
REQ-020 After the 8th SHIFT cycle the FSM SHALL enter DONE with res_valid=1, and res_id/res_count holding the final values.
REQ-021 Latency: for a gnt pulse in cycle T, res_valid SHALL first be high in cycle T+9.
REQ-022 In DONE, res_valid, res_id and res_count SHALL be held stable until a cycle with res_valid & res_ready, after which the FSM SHALL return to IDLE on the next edge.
REQ-023 No gnt SHALL be issued in SHIFT or DONE; req changes and data changes after capture SHALL have no effect on the word in progress.
REQ-024 Simultaneous handshake and pending requests: the new grant SHALL occur in the first IDLE cycle, giving a minimum inter-grant spacing of 10 cycles.
REQ-025 res_id and res_count SHALL be 0 whenever res_valid=0.

Reset
REQ-026 While clear_n=0, the following SHALL hold immediately: FSM in IDLE, detector in D0, gnt=0, busy=0, res_valid=0, res_id=0, res_count=0, round-robin pointer at index 0.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL abort the word with no result delivered; after release, operation SHALL resume from IDLE.

Verification
REQ-028 The bench SHALL cover: req=0001, data[7:0]=0xB0 -> gnt=0001 for one cycle; 9 cycles later res_valid=1, res_id=0, res_count=1.
REQ-029 The bench SHALL cover: data[15:8]=0xBB, req=0010 -> res_id=1, res_count=2.
REQ-030 The bench SHALL cover: data word 0x0D (trailing partial match) -> res_count=0.
REQ-031 The bench SHALL cover: req=1111 held, res_ready=1 -> grant order 0,1,2,3,0, with grants 10 cycles apart.
REQ-032 The bench SHALL cover: res_ready=0 for 5 cycles in DONE with req=1111 -> outputs stable, gnt=0, busy=1; on res_ready=1, the next grant is 1 cycle after the handshake.
REQ-033 The bench SHALL cover: clear_n pulsed low at SHIFT bit 4 -> all outputs 0 during reset; then req=1000 -> gnt=1000 and a correct result for data[31:24].
